// File: rtl/mbx_pkg.sv
// Shared types and constants for the mailbox memory request sequencer.
package mbx_pkg;

  typedef logic [3:0] word_mask_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FREE = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    XFER      = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [5:0] NXM_TIMEOUT = 6'd63;

  function automatic logic [1:0] lowest_idx(input word_mask_t m);
    if (m[0]) begin
      return 2'd0;
    end else if (m[1]) begin
      return 2'd1;
    end else if (m[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/mbx_nxm_timer.sv
// Acknowledge timeout counter; expire fires on the cycle the count would reach NXM_TIMEOUT.
module mbx_nxm_timer
  import mbx_pkg::*;
(
  input  logic clk_mbx_h,
  input  logic mr_reset_l,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [5:0] count;

  // Count wait cycles while enabled; clear dominates.
  always_ff @(posedge clk_mbx_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      count <= 6'd0;
    end else if (clr) begin
      count <= 6'd0;
    end else if (en) begin
      count <= count + 6'd1;
    end else begin
      count <= count;
    end
  end

  assign expire = en && (count == (NXM_TIMEOUT - 6'd1));

endmodule

// File: rtl/mbx_mem_rq_seq.sv
// Sequences one cache memory request: wait for the port, start, acknowledge, word transfer, done.
module mbx_mem_rq_seq
  import mbx_pkg::*;
(
  input  logic       clk_mbx_h,
  input  logic       mr_reset_l,
  input  logic       csh_mem_rq_l,
  input  logic       csh_rq_wr_h,
  input  logic [3:0] csh_word_mask_h,
  input  logic       core_busy_h,
  input  logic       mem_ackn_h,
  input  logic       mem_data_valid_l,
  output logic       mbx5_rq_0_in_h,
  output logic       mbx5_rq_1_in_h,
  output logic       mbx5_rq_2_in_h,
  output logic       mbx5_rq_3_in_h,
  output logic       mbx5_mem_rd_rq_in_h,
  output logic       mbx5_mem_wr_rq_in_h,
  output logic       mbx_mem_start_l,
  output logic       mbx5_mem_to_c_en_l,
  output logic       mbx3_refill_hold_h,
  output logic [1:0] mbx_word_num_h,
  output logic       mbx_rq_done_l,
  output logic       mbx_nxm_err_h
);

  state_t     state, nxt_state;
  word_mask_t mask_lat, nxt_mask, pend, nxt_pend, pend_clr;
  logic       wr_lat, nxt_wr, nxt_nxm, armed, accept, expire;
  logic       word_ev, last_word, in_cycle, in_hold;
  logic [1:0] nxt_word, low_idx;

  mbx_nxm_timer u_timer (
    .clk_mbx_h  (clk_mbx_h),
    .mr_reset_l (mr_reset_l),
    .clr        (state != WAIT_ACK),
    .en         ((state == WAIT_ACK) && !mem_ackn_h),
    .expire     (expire)
  );

  assign pend_clr  = pend & (pend - 4'b0001);
  assign low_idx   = lowest_idx(pend);
  assign last_word = (pend_clr == 4'b0000);
  // A data-valid with nothing pending is dropped.
  assign word_ev   = !mem_data_valid_l && (pend != 4'b0000);

  // Next-state and next-datapath decode.
  always_comb begin
    nxt_state = state;
    nxt_mask  = mask_lat;
    nxt_pend  = pend;
    nxt_wr    = wr_lat;
    nxt_nxm   = mbx_nxm_err_h;
    nxt_word  = mbx_word_num_h;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (!csh_mem_rq_l && armed) begin
          accept    = 1'b1;
          nxt_mask  = csh_word_mask_h;
          nxt_pend  = csh_word_mask_h;
          nxt_wr    = csh_rq_wr_h;
          nxt_nxm   = 1'b0;
          nxt_word  = 2'd0;
          nxt_state = (csh_word_mask_h == 4'b0000) ? DONE : WAIT_FREE;
        end else begin
          nxt_state = IDLE;
        end
      end
      WAIT_FREE: begin
        if (core_busy_h) begin
          nxt_state = WAIT_FREE;
        end else begin
          nxt_state = START;
        end
      end
      START: nxt_state = WAIT_ACK;
      WAIT_ACK: begin
        if (mem_ackn_h) begin
          if (word_ev) begin
            nxt_word  = low_idx;
            nxt_pend  = pend_clr;
            nxt_state = last_word ? DONE : XFER;
          end else begin
            nxt_state = XFER;
          end
        end else if (expire) begin
          nxt_nxm   = 1'b1;
          nxt_state = DONE;
        end else begin
          nxt_state = WAIT_ACK;
        end
      end
      XFER: begin
        if (word_ev) begin
          nxt_word  = low_idx;
          nxt_pend  = pend_clr;
          nxt_state = last_word ? DONE : XFER;
        end else begin
          nxt_state = XFER;
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign in_cycle = (nxt_state == WAIT_FREE) || (nxt_state == START) ||
                    (nxt_state == WAIT_ACK)  || (nxt_state == XFER);
  assign in_hold  = ((nxt_state == START) || (nxt_state == WAIT_ACK) ||
                     (nxt_state == XFER)) && !nxt_wr;

  // State, datapath and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk_mbx_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      state               <= IDLE;
      mask_lat            <= 4'b0000;
      pend                <= 4'b0000;
      wr_lat              <= 1'b0;
      armed               <= 1'b0;
      mbx_nxm_err_h       <= 1'b0;
      mbx_word_num_h      <= 2'd0;
      {mbx5_rq_3_in_h, mbx5_rq_2_in_h, mbx5_rq_1_in_h, mbx5_rq_0_in_h} <= 4'b0000;
      mbx5_mem_rd_rq_in_h <= 1'b0;
      mbx5_mem_wr_rq_in_h <= 1'b0;
      mbx_mem_start_l     <= 1'b1;
      mbx5_mem_to_c_en_l  <= 1'b1;
      mbx3_refill_hold_h  <= 1'b0;
      mbx_rq_done_l       <= 1'b1;
    end else begin
      state          <= nxt_state;
      mask_lat       <= nxt_mask;
      pend           <= nxt_pend;
      wr_lat         <= nxt_wr;
      mbx_nxm_err_h  <= nxt_nxm;
      mbx_word_num_h <= nxt_word;
      // A new request needs csh_mem_rq_l seen high since the last acceptance or reset.
      if (accept) begin
        armed <= 1'b0;
      end else if (csh_mem_rq_l) begin
        armed <= 1'b1;
      end else begin
        armed <= armed;
      end
      {mbx5_rq_3_in_h, mbx5_rq_2_in_h, mbx5_rq_1_in_h, mbx5_rq_0_in_h} <=
        in_cycle ? nxt_mask : 4'b0000;
      mbx5_mem_rd_rq_in_h <= in_cycle && !nxt_wr;
      mbx5_mem_wr_rq_in_h <= in_cycle && nxt_wr;
      mbx_mem_start_l     <= (nxt_state != START);
      mbx5_mem_to_c_en_l  <= !((nxt_state == XFER) && !nxt_wr);
      mbx3_refill_hold_h  <= in_hold;
      mbx_rq_done_l       <= (nxt_state != DONE);
    end
  end

endmodule

// File: tb/tb_mbx_mem_rq_seq.sv
// Directed bench for mbx_mem_rq_seq: per-cycle vector table plus hand-written corner sequences.
module tb_mbx_mem_rq_seq;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       req_l, wr, busy, ackn, dv_l;
  logic [3:0] mask;
  logic       rq0, rq1, rq2, rq3, rd, wrq, start_l, toc_l, hold, done_l, nxm;
  logic [1:0] word;
  logic [12:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        req_l;
    logic        wr;
    logic [3:0]  mask;
    logic        busy;
    logic        ackn;
    logic        dv_l;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  mbx_mem_rq_seq dut (
    .clk_mbx_h           (clk),
    .mr_reset_l          (rst_l),
    .csh_mem_rq_l        (req_l),
    .csh_rq_wr_h         (wr),
    .csh_word_mask_h     (mask),
    .core_busy_h         (busy),
    .mem_ackn_h          (ackn),
    .mem_data_valid_l    (dv_l),
    .mbx5_rq_0_in_h      (rq0),
    .mbx5_rq_1_in_h      (rq1),
    .mbx5_rq_2_in_h      (rq2),
    .mbx5_rq_3_in_h      (rq3),
    .mbx5_mem_rd_rq_in_h (rd),
    .mbx5_mem_wr_rq_in_h (wrq),
    .mbx_mem_start_l     (start_l),
    .mbx5_mem_to_c_en_l  (toc_l),
    .mbx3_refill_hold_h  (hold),
    .mbx_word_num_h      (word),
    .mbx_rq_done_l       (done_l),
    .mbx_nxm_err_h       (nxm)
  );

  always #5 clk = ~clk;

  assign obs = {rq3, rq2, rq1, rq0, rd, wrq, start_l, toc_l, hold, word, done_l, nxm};

  // Expected output bundle in the same order as obs.
  function automatic logic [12:0] E(input logic [3:0] r, input logic d, input logic w,
                                    input logic st, input logic tc, input logic h,
                                    input logic [1:0] wn, input logic dn, input logic nx);
    return {r, d, w, st, tc, h, wn, dn, nx};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %013b expected %013b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic r, input logic w, input logic [3:0] m,
                     input logic b, input logic a, input logic d);
    req_l = r; wr = w; mask = m; busy = b; ackn = a; dv_l = d;
  endtask

  task automatic add(input logic r, input logic w, input logic [3:0] m,
                     input logic b, input logic a, input logic d, input logic [12:0] e);
    vec_t v;
    v.req_l = r; v.wr = w; v.mask = m; v.busy = b; v.ackn = a; v.dv_l = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [12:0] idle_rst;
    idle_rst = E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);

    // Full read refill 1111, ackn three cycles after start, one gap in data-valid.
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
    // Request still low after done: no restart until it has been high.
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0));
    add(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0));
    // Sparse read 1010 with a short busy stall and ackn+data-valid together.
    add(1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, E(4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, E(4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, E(4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, E(4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0, E(4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
    add(1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0));
    // Single-word write: no cache steering, no refill hold.
    add(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, E(4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, E(4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, E(4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, E(4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
    add(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    // Empty mask goes straight to done.
    add(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    // One word taken with the ackn finishes without ever entering XFER.
    add(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1, E(4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1, E(4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1, E(4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 4'h4, 1'b0, 1'b1, 1'b0, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0));
    add(1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0));

    rst_l = 1'b0;
    set(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("reset_state", obs, idle_rst);
    rst_l = 1'b1;
    tick();
    chk("idle_after_reset", obs, idle_rst);

    for (int i = 0; i < vecs.size(); i++) begin
      set(vecs[i].req_l, vecs[i].wr, vecs[i].mask, vecs[i].busy, vecs[i].ackn, vecs[i].dv_l);
      tick();
      chk($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Busy stall: start only on the cycle after busy falls.
    set(1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("stall_accept", obs, E(4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_no_start%0d", i), {12'd0, start_l}, 13'd1);
    end
    busy = 1'b0;
    tick();
    chk("stall_start", obs, E(4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    tick();
    chk("stall_start_once", obs, E(4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    ackn = 1'b1;
    tick();
    ackn = 1'b0; dv_l = 1'b0;
    tick();
    tick();
    chk("stall_done", obs, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0));
    set(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();

    // No acknowledge: nxm 63 cycles after START exits, sticky until next acceptance.
    set(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("nxm_start", {12'd0, start_l}, 13'd0);
    tick();
    repeat (62) tick();
    chk("nxm_not_yet", obs, E(4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
    tick();
    chk("nxm_set_done", obs, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1));
    tick();
    chk("nxm_sticky_idle", obs, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1));
    req_l = 1'b1;
    tick();
    chk("nxm_sticky_rq_high", {12'd0, nxm}, 13'd1);
    set(1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
    tick();
    chk("nxm_cleared", obs, E(4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    tick();
    tick();
    ackn = 1'b1; dv_l = 1'b0;
    tick();
    chk("nxm_next_done", obs, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0));
    set(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset in XFER after the first of four words.
    set(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    ackn = 1'b1;
    tick();
    ackn = 1'b0; dv_l = 1'b0;
    tick();
    chk("rst_pre_word0", obs, E(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0));
    dv_l = 1'b1;
    #2 rst_l = 1'b0;
    #1 chk("rst_async", obs, idle_rst);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rst_held%0d", i), obs, idle_rst);
    end
    rst_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_no_fresh_edge%0d", i), obs, idle_rst);
    end
    req_l = 1'b1;
    tick();
    set(1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rst_fresh_accept", obs, E(4'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    tick();
    tick();
    ackn = 1'b1; dv_l = 1'b0;
    tick();
    chk("rst_fresh_done", obs, E(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
    set(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mbx_mem_rq_seq.md
MBX_MEM_RQ_SEQ -- requirements
Module: mbx_mem_rq_seq

Interface
REQ-001 SHALL have port clk_mbx_h, input, 1: the only clock; all state changes on its rising edge.
REQ-002 SHALL have port mr_reset_l, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port csh_mem_rq_l, input, 1: cache requests a memory cycle; active-low, level held until done.
REQ-004 SHALL have port csh_rq_wr_h, input, 1: sampled with the request; 1 = write (writeback), 0 = read (refill).
REQ-005 SHALL have port csh_word_mask_h, input, 4: quadword words wanted; bit n maps to rq_n.
REQ-006 SHALL have port core_busy_h, input, 1: memory port busy; no start while high.
REQ-007 SHALL have port mem_ackn_h, input, 1: memory acknowledges the start.
REQ-008 SHALL have port mem_data_valid_l, input, 1: one word transferred per low cycle.
REQ-009 SHALL have port mbx5_rq_0_in_h … mbx5_rq_3_in_h, output, 1 each: latched word requests to the MBC.
REQ-010 SHALL have port mbx5_mem_rd_rq_in_h, output, 1: read cycle in progress.
REQ-011 SHALL have port mbx5_mem_wr_rq_in_h, output, 1: write cycle in progress.
REQ-012 SHALL have port mbx_mem_start_l, output, 1: one-cycle start pulse, active-low.
REQ-013 SHALL have port mbx5_mem_to_c_en_l, output, 1: low while read data is steered to the cache.
REQ-014 SHALL have port mbx3_refill_hold_h, output, 1: high from start until the last read word.
REQ-015 SHALL have port mbx_word_num_h, output, 2: number of the word currently expected.
REQ-016 SHALL have port mbx_rq_done_l, output, 1: one-cycle completion pulse, active-low.
REQ-017 SHALL have port mbx_nxm_err_h, output, 1: sticky non-existent-memory flag.

Function
REQ-018 SHALL implement states IDLE, WAIT_FREE, START, WAIT_ACK, XFER and DONE.
REQ-019 IDLE: when csh_mem_rq_l is low, SHALL latch the mask and direction and go to WAIT_FREE; a mask of 0000 SHALL go straight to DONE.
REQ-020 WAIT_FREE: SHALL stay while core_busy_h is 1, and go to START on the first cycle it is 0.
REQ-021 START: SHALL drive mbx_mem_start_l low for exactly one cycle, then go to WAIT_ACK.
REQ-022 WAIT_ACK: on mem_ackn_h, SHALL go to XFER.
REQ-023 WAIT_ACK timeout: a 6-bit counter SHALL run; if the count reaches 63 without ackn, SHALL set mbx_nxm_err_h and go to DONE.
REQ-024 XFER, one word per mem_data_valid_l low cycle: SHALL clear the lowest set mask bit and report its index on mbx_word_num_h; when the last bit clears, SHALL go to DONE.
REQ-025 XFER data-valid with an empty mask: SHALL be ignored.
REQ-026 DONE: SHALL pulse mbx_rq_done_l for one cycle, then return to IDLE.
REQ-027 DONE with csh_mem_rq_l still low: SHALL NOT start a new cycle until the request has been high for at least one cycle.
REQ-028 rq/rd/wr outputs: SHALL be registered and valid from WAIT_FREE through XFER, and 0 otherwise.
REQ-029 mbx5_mem_to_c_en_l: SHALL be low only in XFER for reads.
REQ-030 mbx3_refill_hold_h: SHALL be high from START through XFER for reads.
REQ-031 ackn and data-valid in the same cycle in WAIT_ACK: SHALL take the ackn and count the word, and may finish at once.
REQ-032 Clearing mbx_nxm_err_h: SHALL clear only on reset or on acceptance of the next request.
REQ-033 Request path latency: request in to start pulse SHALL be 2 cycles minimum with core_busy_h low.

Reset
REQ-034 While mr_reset_l is low, SHALL be in IDLE: all rq/rd/wr outputs 0, mbx_mem_start_l, mbx5_mem_to_c_en_l and mbx_rq_done_l all 1, mbx3_refill_hold_h 0, mbx_word_num_h 00, mbx_nxm_err_h 0, counters 0.
REQ-035 Reset asserted mid-cycle: SHALL abort with no done pulse; after release the block SHALL wait for a fresh request edge.

Structure
REQ-036 Shared package mbx_pkg SHALL hold: the state enum, NXM_TIMEOUT = 63, and the word mask type.
REQ-037 Sub-module mbx_nxm_timer SHALL hold the 6-bit timeout counter with clear/enable/expire; all other logic SHALL stay in one module.

Verification
REQ-038 Read refill: mask 1111, busy low, ackn 3 cycles after start, 4 data-valids -> word_num 0,1,2,3; refill_hold drops after word 3; one done pulse.
REQ-039 Sparse read: mask 1010 -> word_num 1 then 3; done after the second data-valid.
REQ-040 Busy stall: core_busy_h high for 10 cycles -> start exactly 1 cycle after busy falls; no earlier start.
REQ-041 NXM: no ackn -> nxm_err set 63 cycles after START exits; done pulses; next request clears the flag.
REQ-042 Write: wr=1, mask 0001 -> mem_wr_rq high, mem_to_c_en_l stays high, refill_hold stays 0.
REQ-043 Reset in XFER after word 1 of 4 -> all outputs at reset values, no done pulse, IDLE on release.
